// File: rtl/clk_reconfig_pkg.sv
// Shared types and clocking-wizard register map for the clock reconfiguration sequencer.
package clk_reconfig_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_FB,
      S_WR_OUT0,
      S_WR_LOAD,
      S_POLL_AR,
      S_POLL_R,
      S_GAP,
      S_ERR
   } state_t;

   localparam logic [11:0] CLKW_STATUS = 12'h004;
   localparam logic [11:0] CLKW_CFG0   = 12'h200;
   localparam logic [11:0] CLKW_CFG2   = 12'h208;
   localparam logic [11:0] CLKW_CFG23  = 12'h25C;

   localparam logic [31:0] LOAD_SEN      = 32'h3;
   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

   function automatic logic is_write_state(input state_t s);
      return (s == S_WR_FB) || (s == S_WR_OUT0) || (s == S_WR_LOAD);
   endfunction

endpackage

// File: rtl/clk_reconfig_ctrl_axil_single_write.sv
// One AXI4-Lite write: raises AW/W together on i_start, drops each after its handshake, then takes B.
module axil_single_write
   import clk_reconfig_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_data,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [31:0]       o_wdata,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready
);

   logic r_active, r_awvalid, r_wvalid, r_aw_done, r_w_done;
   logic w_aw_hs, w_w_hs, w_b_hs;

   assign w_aw_hs = r_awvalid & i_awready;
   assign w_w_hs  = r_wvalid & i_wready;

   // Ready may follow the same-cycle AW/W handshake, so a B beat coincident with the last one is taken.
   assign o_bready = r_active & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
   assign w_b_hs   = o_bready & i_bvalid;

   assign o_done    = w_b_hs & (i_bresp == AXI_RESP_OKAY);
   assign o_err     = w_b_hs & (i_bresp != AXI_RESP_OKAY);
   assign o_awvalid = r_awvalid;
   assign o_wvalid  = r_wvalid;
   assign o_awaddr  = i_addr;
   assign o_wdata   = i_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_active  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (i_start) begin
         r_active  <= 1'b1;
         r_awvalid <= 1'b1;
         r_wvalid  <= 1'b1;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
         end
         if (w_b_hs) r_active <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_reconfig_ctrl.sv
// Clocking-wizard reprogramming sequencer (AXI4-Lite master): write config, load, poll lock.
// Optional poll timeout enabled by defining CLK_RECONFIG_TIMEOUT_EN.
module clk_reconfig_ctrl
   import clk_reconfig_pkg::*;
#(
   parameter int POLL_GAP   = 16,
   parameter int MAX_POLLS  = 1024,
   parameter int AXI_ADDR_W = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   input  logic [7:0]            cfg_div_i,
   input  logic [7:0]            cfg_mult_i,
   input  logic [7:0]            cfg_clkout_div_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  rst_hold_no,
   output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [AXI_ADDR_W-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int GAP_W = $clog2(POLL_GAP + 1);

   state_t                  r_state, w_next;
   logic [7:0]              r_div, r_mult, r_clkout_div;
   logic                    r_done, r_reject;
   logic [GAP_W-1:0]        r_gap_cnt;
   logic                    w_accept, w_cfg_zero, w_locked, w_rresp_ok, w_gap_last, w_poll_limit;
   logic                    w_wr_start, w_wr_done, w_wr_err;
   logic [AXI_ADDR_W-1:0]   w_wr_addr;
   logic [31:0]             w_wr_data;
   logic                    w_unused_rdata;

   assign w_accept       = cfg_valid_i & cfg_ready_o;
   assign w_cfg_zero     = (cfg_div_i == 8'd0) | (cfg_mult_i == 8'd0) | (cfg_clkout_div_i == 8'd0);
   assign w_locked       = m_axi_rdata[0];
   assign w_rresp_ok     = (m_axi_rresp == AXI_RESP_OKAY);
   assign w_gap_last     = (r_gap_cnt == GAP_W'(POLL_GAP - 1));
   assign w_unused_rdata = ^m_axi_rdata[31:1];

`ifdef CLK_RECONFIG_TIMEOUT_EN
   localparam int POLL_W = $clog2(MAX_POLLS + 1);
   logic [POLL_W-1:0] r_poll_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_poll_cnt <= '0;
      else if (w_accept)
         r_poll_cnt <= '0;
      else if ((r_state == S_POLL_R) && m_axi_rvalid && w_rresp_ok && !w_locked)
         r_poll_cnt <= r_poll_cnt + POLL_W'(1);
   end

   // This read is the MAX_POLLS-th unlocked one, so it goes to ERR instead of GAP.
   assign w_poll_limit = (r_poll_cnt == POLL_W'(MAX_POLLS - 1));
`else
   localparam int unused_max_polls = MAX_POLLS;
   assign w_poll_limit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      // NOTE: default first so no branch leaves w_next unassigned and a latch is inferred.
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (cfg_valid_i && !w_cfg_zero) w_next = S_WR_FB;
         S_WR_FB:   if (w_wr_err) w_next = S_ERR; else if (w_wr_done) w_next = S_WR_OUT0;
         S_WR_OUT0: if (w_wr_err) w_next = S_ERR; else if (w_wr_done) w_next = S_WR_LOAD;
         S_WR_LOAD: if (w_wr_err) w_next = S_ERR; else if (w_wr_done) w_next = S_POLL_AR;
         S_POLL_AR: if (m_axi_arready) w_next = S_POLL_R;
         S_POLL_R:
            if (m_axi_rvalid) begin
               if (!w_rresp_ok)       w_next = S_ERR;
               else if (w_locked)     w_next = S_IDLE;
               else if (w_poll_limit) w_next = S_ERR;
               else                   w_next = S_GAP;
            end
         S_GAP:     if (w_gap_last) w_next = S_POLL_AR;
         S_ERR:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o   = 1'b0;
      busy_o        = 1'b1;
      rst_hold_no   = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_araddr  = '0;
      m_axi_rready  = 1'b0;
      w_wr_addr     = '0;
      w_wr_data     = '0;
      unique case (r_state)
         S_IDLE: begin
            cfg_ready_o = 1'b1;
            busy_o      = 1'b0;
            rst_hold_no = 1'b1;
         end
         S_WR_FB: begin
            w_wr_addr = AXI_ADDR_W'(CLKW_CFG0);
            w_wr_data = {16'h0, r_mult, r_div};
         end
         S_WR_OUT0: begin
            w_wr_addr = AXI_ADDR_W'(CLKW_CFG2);
            w_wr_data = {24'h0, r_clkout_div};
         end
         S_WR_LOAD: begin
            w_wr_addr = AXI_ADDR_W'(CLKW_CFG23);
            w_wr_data = LOAD_SEN;
         end
         S_POLL_AR: begin
            m_axi_arvalid = 1'b1;
            m_axi_araddr  = AXI_ADDR_W'(CLKW_STATUS);
         end
         S_POLL_R: m_axi_rready = 1'b1;
         default: ;
      endcase
   end

   assign done_o      = r_done;
   assign err_o       = r_reject | (r_state == S_ERR);
   assign m_axi_wstrb = 4'hF;
   assign w_wr_start  = (w_next != r_state) && is_write_state(w_next);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_div        <= '0;
         r_mult       <= '0;
         r_clkout_div <= '0;
         r_done       <= 1'b0;
         r_reject     <= 1'b0;
         r_gap_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_div        <= cfg_div_i;
            r_mult       <= cfg_mult_i;
            r_clkout_div <= cfg_clkout_div_i;
         end
         r_reject  <= w_accept & w_cfg_zero;
         r_done    <= (r_state == S_POLL_R) && (w_next == S_IDLE);
         r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
      end
   end

   axil_single_write #(.ADDR_W(AXI_ADDR_W)) u_write (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_start   (w_wr_start),
      .i_addr    (w_wr_addr),
      .i_data    (w_wr_data),
      .o_done    (w_wr_done),
      .o_err     (w_wr_err),
      .o_awaddr  (m_axi_awaddr),
      .o_awvalid (m_axi_awvalid),
      .i_awready (m_axi_awready),
      .o_wdata   (m_axi_wdata),
      .o_wvalid  (m_axi_wvalid),
      .i_wready  (m_axi_wready),
      .i_bresp   (m_axi_bresp),
      .i_bvalid  (m_axi_bvalid),
      .o_bready  (m_axi_bready)
   );

endmodule

// File: tb/tb_clk_reconfig_ctrl.sv
// Self-checking bench: AXI-Lite wizard slave model, protocol monitor and directed/random requests.
module tb_clk_reconfig_ctrl;

   localparam int POLL_GAP  = 4;
   localparam int MAX_POLLS = 3;
   localparam int AW        = 11;

   logic          clk_i, rst_ni;
   logic          cfg_valid_i, cfg_ready_o;
   logic [7:0]    cfg_div_i, cfg_mult_i, cfg_clkout_div_i;
   logic          busy_o, done_o, err_o, rst_hold_no;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic          m_axi_awvalid, m_axi_awready;
   logic [31:0]   m_axi_wdata, m_axi_rdata;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_wvalid, m_axi_wready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready;
   logic          m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;

   clk_reconfig_ctrl #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS), .AXI_ADDR_W(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_div_i(cfg_div_i), .cfg_mult_i(cfg_mult_i), .cfg_clkout_div_i(cfg_clkout_div_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rst_hold_no(rst_hold_no),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave behaviour knobs
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly, lock_after;
   bit          err_en;
   logic [AW-1:0] err_addr;

   // Observations, cleared at the start of each request
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   int aw_beats, w_beats, b_beats, ar_beats, r_beats;
   int viol, hold_bad, valid_cycles, busy_cycles, done_pulses, err_pulses, done_bad;
   int ar_idle_min, ar_idle_run;
   bit ar_seen;

   // Slave + monitor: inspects at negedge, drives, then resolves handshakes 1 time unit later
   initial begin : slave
      int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      bit aw_got, w_got, b_pend, r_pend;
      bit aw_hs, w_hs, ar_hs;
      bit p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs, p_hold;
      logic [AW-1:0] got_addr, p_awaddr, p_araddr;
      logic [31:0] got_data, p_wdata, r_word;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_wv = 0; p_arv = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_hold = 1;
      got_addr = 0; got_data = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0; r_word = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_hold = 1;
            continue;
         end
         if (p_awv && !p_aw_hs && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) viol++;
         if (p_wv && !p_w_hs && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) viol++;
         if (p_arv && !p_ar_hs && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) viol++;
         if (m_axi_wstrb !== 4'hF) viol++;
         if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cycles++;
         if (busy_o) busy_cycles++;
         if (busy_o === rst_hold_no) hold_bad++;
         if (err_o) err_pulses++;
         if (done_o) begin
            done_pulses++;
            if (!rst_hold_no || busy_o || !cfg_ready_o || p_hold) done_bad++;
         end
         if (m_axi_arvalid) begin
            if (!p_arv) begin
               if (ar_seen && ar_idle_run < ar_idle_min) ar_idle_min = ar_idle_run;
               ar_seen = 1;
            end
            ar_idle_run = 0;
         end else ar_idle_run++;
         p_hold = rst_hold_no;

         m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_dly);
         m_axi_wready  = m_axi_wvalid && !w_got && (w_cnt >= w_dly);
         m_axi_bvalid  = b_pend && (b_cnt >= b_dly);
         m_axi_bresp   = (err_en && got_addr == err_addr) ? 2'b10 : 2'b00;
         m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
         m_axi_rvalid  = r_pend && (r_cnt >= r_dly);
         m_axi_rdata   = r_word;
         #1;
         aw_hs = m_axi_awvalid && m_axi_awready;
         w_hs  = m_axi_wvalid && m_axi_wready;
         ar_hs = m_axi_arvalid && m_axi_arready;
         if (aw_hs) begin aw_got = 1; got_addr = m_axi_awaddr; aw_beats++; aw_cnt = 0; end
         else if (m_axi_awvalid) aw_cnt++;
         if (w_hs) begin w_got = 1; got_data = m_axi_wdata; w_beats++; w_cnt = 0; end
         else if (m_axi_wvalid) w_cnt++;
         if (b_pend) begin
            if (m_axi_bvalid && m_axi_bready) begin
               b_pend = 0; b_beats++;
               wr_addr_q.push_back(got_addr);
               wr_data_q.push_back(got_data);
            end else b_cnt++;
         end else if (aw_got && w_got) begin
            b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
         end
         if (r_pend) begin
            if (m_axi_rvalid && m_axi_rready) begin r_pend = 0; r_beats++; end
            else r_cnt++;
         end
         if (ar_hs) begin
            r_word    = $urandom;
            r_word[0] = (ar_beats >= lock_after);
            ar_beats++; ar_cnt = 0; r_pend = 1; r_cnt = 0;
         end else if (m_axi_arvalid) ar_cnt++;
         p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_arv = m_axi_arvalid;
         p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
         p_awaddr = m_axi_awaddr; p_wdata = m_axi_wdata; p_araddr = m_axi_araddr;
      end
   end

   // One request checked against a model built from the sequencer's rules.
   task automatic run_txn(input string tag, input logic [7:0] d, input logic [7:0] m,
                          input logic [7:0] c, input int err_idx, input bit tgl);
      logic [AW-1:0] exp_a[3];
      logic [31:0]   exp_d[3];
      bit reject, werr, tmo, exp_done;
      int n_wr, n_rd, n;
      exp_a[0] = 11'h200; exp_d[0] = {16'h0, m, d};
      exp_a[1] = 11'h208; exp_d[1] = {24'h0, c};
      exp_a[2] = 11'h25C; exp_d[2] = 32'h3;
      reject = (d == 0) || (m == 0) || (c == 0);
      werr   = !reject && err_idx >= 0;
      n_wr   = reject ? 0 : (werr ? err_idx + 1 : 3);
      n_rd   = (reject || werr) ? 0 : lock_after + 1;
      tmo    = 0;
`ifdef CLK_RECONFIG_TIMEOUT_EN
      if (n_rd > MAX_POLLS) begin n_rd = MAX_POLLS; tmo = 1; end
`endif
      exp_done = !(reject || werr || tmo);
      err_en   = werr;
      err_addr = werr ? exp_a[err_idx] : '0;

      @(negedge clk_i); #2;
      wr_addr_q.delete(); wr_data_q.delete();
      aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
      viol = 0; hold_bad = 0; valid_cycles = 0; busy_cycles = 0;
      done_pulses = 0; err_pulses = 0; done_bad = 0;
      ar_idle_min = 1000; ar_idle_run = 0; ar_seen = 0;
      check({tag, "_ready_idle"}, cfg_ready_o, 1'b1);
      cfg_div_i = d; cfg_mult_i = m; cfg_clkout_div_i = c; cfg_valid_i = 1'b1;
      @(negedge clk_i); #2;
      cfg_valid_i = 1'b0;
      if (reject) begin
         check({tag, "_rej_err"}, err_o, 1'b1);
         check({tag, "_rej_busy"}, busy_o, 1'b0);
      end else begin
         check({tag, "_acc_busy"}, busy_o, 1'b1);
         check({tag, "_acc_hold"}, rst_hold_no, 1'b0);
         check({tag, "_acc_ready"}, cfg_ready_o, 1'b0);
         n = 0;
         while (n < 3000) begin
            if (done_o || err_o) break;
            @(negedge clk_i); #2;
            n++;
            if (done_o || err_o) break;
            if (tgl) begin
               cfg_valid_i = $urandom_range(0, 1);
               cfg_div_i = 8'($urandom_range(1, 255));
               cfg_mult_i = 8'($urandom_range(1, 255));
            end
         end
         cfg_valid_i = 1'b0;
         check({tag, "_no_hang"}, (n < 3000), 1'b1);
      end
      repeat (3) @(negedge clk_i);
      #2;
      check({tag, "_wr_cnt"}, wr_addr_q.size(), n_wr);
      for (int i = 0; i < n_wr; i++) begin
         if (i < wr_addr_q.size()) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], exp_a[i]);
            check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_d[i]);
         end
      end
      check({tag, "_aw_beats"}, aw_beats, n_wr);
      check({tag, "_w_beats"}, w_beats, n_wr);
      check({tag, "_ar_beats"}, ar_beats, n_rd);
      check({tag, "_r_beats"}, r_beats, n_rd);
      check({tag, "_done"}, done_pulses, exp_done ? 1 : 0);
      check({tag, "_err"}, err_pulses, exp_done ? 0 : 1);
      check({tag, "_proto_viol"}, viol, 0);
      check({tag, "_hold_vs_busy"}, hold_bad, 0);
      check({tag, "_done_state"}, done_bad, 0);
      if (n_rd >= 2) check({tag, "_ar_gap_ok"}, (ar_idle_min >= POLL_GAP), 1'b1);
      if (reject) begin
         check({tag, "_rej_no_valid"}, valid_cycles, 0);
         check({tag, "_rej_no_busy"}, busy_cycles, 0);
      end
      check({tag, "_end_ready"}, cfg_ready_o, 1'b1);
      check({tag, "_end_hold"}, rst_hold_no, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, cfg_ready_o, 1'b1);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_done"}, done_o, 1'b0);
      check({tag, "_err"}, err_o, 1'b0);
      check({tag, "_hold"}, rst_hold_no, 1'b1);
      check({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
      check({tag, "_readys"}, {m_axi_bready, m_axi_rready}, 2'b00);
      check({tag, "_awaddr"}, m_axi_awaddr, '0);
      check({tag, "_araddr"}, m_axi_araddr, '0);
      check({tag, "_wdata"}, m_axi_wdata, '0);
      check({tag, "_wstrb"}, m_axi_wstrb, 4'hF);
   endtask

   task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                            input int lk);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; lock_after = lk;
   endtask

   initial begin : stim
      int n;
      bit seen;
      rst_ni = 1'b0;
      cfg_valid_i = 1'b0; cfg_div_i = 0; cfg_mult_i = 0; cfg_clkout_div_i = 0;
      set_slave(0, 0, 0, 0, 0, 0);
      err_en = 0; err_addr = 0;
      ar_idle_min = 1000; ar_idle_run = 0; ar_seen = 0;
      #3;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk_i);
      #2 rst_ni = 1'b1;

      set_slave(0, 0, 0, 0, 0, 0);
      run_txn("basic", 8'd1, 8'd10, 8'd20, -1, 0);

      set_slave(3, 0, 5, 0, 0, 0);
      run_txn("skew", 8'd2, 8'd33, 8'd7, -1, 0);

      set_slave(0, 0, 0, 1, 1, 2);
      run_txn("poll3", 8'd5, 8'd64, 8'd9, -1, 0);

      set_slave(0, 1, 0, 0, 0, 0);
      run_txn("bresp_err", 8'd3, 8'd12, 8'd4, 1, 0);

      set_slave(0, 0, 0, 0, 0, 0);
      run_txn("zero_mult", 8'd4, 8'd0, 8'd6, -1, 0);

`ifdef CLK_RECONFIG_TIMEOUT_EN
      set_slave(0, 0, 0, 0, 0, 1000);
      run_txn("timeout", 8'd1, 8'd20, 8'd10, -1, 0);
`endif

      for (int i = 0; i < 8; i++) begin
         logic [7:0] d, m, c;
         int e;
         set_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         d = 8'($urandom_range(1, 255));
         m = 8'($urandom_range(1, 255));
         c = 8'($urandom_range(1, 255));
         if ($urandom_range(0, 7) == 0) c = 8'd0;
         e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
         run_txn($sformatf("rnd%0d", i), d, m, c, e, 1);
      end

      // Asynchronous reset while the read data phase is pending
      set_slave(0, 0, 0, 0, 50, 0);
      err_en = 0;
      @(negedge clk_i); #2;
      cfg_div_i = 8'd1; cfg_mult_i = 8'd8; cfg_clkout_div_i = 8'd8; cfg_valid_i = 1'b1;
      @(negedge clk_i); #2;
      cfg_valid_i = 1'b0;
      n = 0; seen = 0;
      while (n < 500) begin
         if (m_axi_rready) begin seen = 1; break; end
         @(negedge clk_i); #2;
         n++;
      end
      check("rst_reach_poll_r", seen, 1'b1);
      #1 rst_ni = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk_i); #2 rst_ni = 1'b1;

      set_slave(1, 2, 1, 0, 0, 1);
      run_txn("post_rst", 8'd2, 8'd40, 8'd5, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
